vstore_mem_if: RTL and testbench



---
 rtl/vstore_mem_if.sv | 119 +++++++++++
 tb/tb_vstore_mem_if.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vstore_mem_if.sv
// Store-side memory interface: turns a store descriptor plus a stream of VRF-word
// operands into word-aligned, byte-enabled writes, then waits for all acks before reporting done.
module vstore_mem_if #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned VRFWordWidthB  = 8,
    parameter int unsigned VlenWidth      = 16,
    parameter int unsigned InsnIdWidth    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       st_req_valid_i,
    output logic                       st_req_ready_o,
    input  logic [AddrWidth-1:0]       st_base_i,
    input  logic [VlenWidth-1:0]       st_vlB_i,
    input  logic [InsnIdWidth-1:0]     st_insn_id_i,
    input  logic                       store_op_valid_i,
    input  logic [8*VRFWordWidthB-1:0] store_op_i,
    output logic                       store_op_gnt_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [AddrWidth-1:0]       mem_addr_o,
    output logic [8*VRFWordWidthB-1:0] mem_wdata_o,
    output logic [VRFWordWidthB-1:0]   mem_be_o,
    input  logic                       mem_ack_i,
    output logic                       done_o,
    output logic [InsnIdWidth-1:0]     done_insn_id_o,
    input  logic                       done_gnt_i
);
    typedef logic [VlenWidth-1:0]   vlen_t;
    typedef logic [InsnIdWidth-1:0] insn_id_t;

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state, w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    vlen_t               r_rem;
    insn_id_t            r_id;
    logic [CntWidth-1:0] r_cnt, w_cnt_nxt;

    logic w_req, w_fire, w_ack, w_last;
    logic [VRFWordWidthB-1:0] w_be;
    logic [AddrWidth-1:0]     w_base_aligned;

    // Request depends only on registered count, so acks never reach mem_req_o combinationally.
    assign w_req  = (r_state == S_ISSUE) && store_op_valid_i
                    && (r_cnt < CntWidth'(MaxOutstanding));
    assign w_fire = w_req && mem_gnt_i;
    assign w_ack  = mem_ack_i && (r_cnt != '0);
    assign w_last = (r_rem <= vlen_t'(VRFWordWidthB));
    assign w_base_aligned = st_base_i & ~AddrWidth'(VRFWordWidthB - 1);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_fire, w_ack})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Byte b is written iff more than b bytes remain; covers both full and tail beats.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < int'(VRFWordWidthB); b++) begin
            w_be[b] = (r_state == S_ISSUE) && (r_rem > vlen_t'(b));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (st_req_valid_i) w_state_nxt = (st_vlB_i == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_fire && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_cnt_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (done_gnt_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rem   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && st_req_valid_i) begin
                r_addr <= w_base_aligned;
                r_rem  <= st_vlB_i;
                r_id   <= st_insn_id_i;
            end else if (w_fire) begin
                r_addr <= r_addr + AddrWidth'(VRFWordWidthB);
                r_rem  <= w_last ? '0 : r_rem - vlen_t'(VRFWordWidthB);
            end
        end
    end

    assign st_req_ready_o = (r_state == S_IDLE) && rst_ni;
    assign mem_req_o      = w_req;
    assign store_op_gnt_o = w_fire;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = store_op_i;
    assign mem_be_o       = w_be;
    assign done_o         = (r_state == S_DONE);
    assign done_insn_id_o = r_id;

    // An ack while writes should be in flight but none are counted is a protocol error.
    a_no_spurious_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_ack_i && (r_cnt == '0) && (r_state == S_ISSUE || r_state == S_DRAIN)));
endmodule

// File: tb/tb_vstore_mem_if.sv
// Directed bench for vstore_mem_if: 8-byte words, MaxOutstanding = 4.
module tb_vstore_mem_if;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_req_valid_i;
    logic        st_req_ready_o;
    logic [31:0] st_base_i;
    logic [15:0] st_vlB_i;
    logic [3:0]  st_insn_id_i;
    logic        store_op_valid_i;
    logic [63:0] store_op_i;
    logic        store_op_gnt_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic        mem_ack_i;
    logic        done_o;
    logic [3:0]  done_insn_id_o;
    logic        done_gnt_i;

    logic        ack_auto, ack_man;
    logic [1:0]  ack_pipe = 2'b00;
    logic [31:0] q_addr[$];
    logic [7:0]  q_be[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;

    vstore_mem_if #(.MaxOutstanding(4), .AddrWidth(32), .VRFWordWidthB(8),
                    .VlenWidth(16), .InsnIdWidth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o),
        .st_base_i(st_base_i), .st_vlB_i(st_vlB_i), .st_insn_id_i(st_insn_id_i),
        .store_op_valid_i(store_op_valid_i), .store_op_i(store_op_i),
        .store_op_gnt_o(store_op_gnt_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
        .done_o(done_o), .done_insn_id_o(done_insn_id_o), .done_gnt_i(done_gnt_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: every granted write is acknowledged two cycles later.
    assign mem_ack_i = ack_auto ? ack_pipe[1] : ack_man;
    always @(posedge clk_i) begin
        ack_pipe <= {ack_pipe[0], mem_req_o & mem_gnt_i};
        if (mem_req_o && mem_gnt_i) begin
            q_addr.push_back(mem_addr_o);
            q_be.push_back(mem_be_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic desc(input logic [31:0] base, input logic [15:0] vlb, input logic [3:0] id);
        st_req_valid_i = 1'b1;
        st_base_i      = base;
        st_vlB_i       = vlb;
        st_insn_id_i   = id;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o && cyc < 20) begin
            @(negedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic done_pulse;
        done_gnt_i = 1'b1;
        @(negedge clk_i);
        done_gnt_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; st_req_valid_i = 1'b0; st_base_i = '0; st_vlB_i = '0;
        st_insn_id_i = '0; store_op_valid_i = 1'b0; store_op_i = 64'hDEAD_BEEF_0123_4567;
        mem_gnt_i = 1'b0; done_gnt_i = 1'b0; ack_auto = 1'b1; ack_man = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i); #1;
        chk("rst_ready", st_req_ready_o, 0);
        chk("rst_req",   mem_req_o, 0);
        chk("rst_opgnt", store_op_gnt_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_be",    mem_be_o, 0);
        @(negedge clk_i); rst_ni = 1'b1; #1;
        chk("idle_ready", st_req_ready_o, 1);

        // T1: three full beats, acks 2 cycles after each grant
        @(negedge clk_i);
        mem_gnt_i = 1'b1; store_op_valid_i = 1'b1; q_addr.delete(); q_be.delete();
        desc(32'h1000, 16'd24, 4'd5); #1;
        chk("t1_ready", st_req_ready_o, 1);
        @(negedge clk_i); st_req_valid_i = 1'b0; #1;
        chk("t1_req",   mem_req_o, 1);
        chk("t1_addr",  mem_addr_o, 32'h1000);
        chk("t1_be",    mem_be_o, 8'hFF);
        chk("t1_wdata", mem_wdata_o, 64'hDEAD_BEEF_0123_4567);
        chk("t1_opgnt", store_op_gnt_o, 1);
        repeat (4) @(negedge clk_i); #1;
        chk("t1_done_early", done_o, 0);
        @(negedge clk_i); #1;
        chk("t1_done", done_o, 1);
        chk("t1_id",   done_insn_id_o, 4'd5);
        done_pulse(); #1;
        chk("t1_done_clr", done_o, 0);
        chk("t1_idle",     st_req_ready_o, 1);
        chk("t1_nbeats",   q_addr.size(), 3);
        if (q_addr.size() == 3) begin
            chk("t1_a0", q_addr[0], 32'h1000);
            chk("t1_a1", q_addr[1], 32'h1008);
            chk("t1_a2", q_addr[2], 32'h1010);
            chk("t1_be2", q_be[2], 8'hFF);
        end

        // T2: unaligned base, 11 bytes -> tail beat with 3 byte enables
        @(negedge clk_i); desc(32'h2005, 16'd11, 4'd9);
        @(negedge clk_i); st_req_valid_i = 1'b0; #1;
        chk("t2_addr0", mem_addr_o, 32'h2000);
        chk("t2_be0",   mem_be_o, 8'hFF);
        @(negedge clk_i); #1;
        chk("t2_addr1", mem_addr_o, 32'h2008);
        chk("t2_be1",   mem_be_o, 8'h07);
        chk("t2_req1",  mem_req_o, 1);
        @(negedge clk_i); #1;
        chk("t2_drain_req", mem_req_o, 0);
        @(negedge clk_i); #1;
        chk("t2_done_early", done_o, 0);
        @(negedge clk_i); #1;
        chk("t2_done", done_o, 1);
        chk("t2_id",   done_insn_id_o, 4'd9);
        done_pulse();

        // T3: acks withheld, 6-beat store throttled at 4 outstanding
        @(negedge clk_i);
        ack_auto = 1'b0; ack_man = 1'b0; q_addr.delete(); q_be.delete();
        desc(32'h3000, 16'd48, 4'd3);
        @(negedge clk_i); st_req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i); #1;
        chk("t3_stall_req", mem_req_o, 0);
        chk("t3_4grants",   q_addr.size(), 4);
        ack_man = 1'b1; #1;
        chk("t3_no_comb_ack", mem_req_o, 0);
        @(negedge clk_i); #1;
        chk("t3_resume", mem_req_o, 1);
        @(negedge clk_i); #1;
        chk("t3_gnt_ack_same", mem_req_o, 1);
        chk("t3_5grants",      q_addr.size(), 5);
        ack_man = 1'b0;
        @(negedge clk_i); #1;
        chk("t3_drain_req", mem_req_o, 0);
        chk("t3_6grants",   q_addr.size(), 6);
        if (q_addr.size() == 6) chk("t3_a5", q_addr[5], 32'h3028);
        ack_man = 1'b1;
        repeat (3) @(negedge clk_i); #1;
        chk("t3_done_early", done_o, 0);
        @(negedge clk_i); #1;
        chk("t3_done", done_o, 1);
        chk("t3_id",   done_insn_id_o, 4'd3);
        ack_man = 1'b0;
        done_pulse();

        // T4: zero-length store, done accepted the cycle it rises
        @(negedge clk_i); ack_auto = 1'b1; q_addr.delete(); q_be.delete();
        desc(32'h4000, 16'd0, 4'd7);
        @(negedge clk_i); st_req_valid_i = 1'b0; #1;
        chk("t4_done", done_o, 1);
        chk("t4_id",   done_insn_id_o, 4'd7);
        chk("t4_req",  mem_req_o, 0);
        done_pulse(); #1;
        chk("t4_idle",   st_req_ready_o, 1);
        chk("t4_nbeats", q_addr.size(), 0);

        // T5: done held 5 cycles while the next descriptor waits
        @(negedge clk_i); desc(32'h5000, 16'd0, 4'd1);
        @(negedge clk_i); desc(32'h5000, 16'd8, 4'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_blocked", st_req_ready_o, 0);
            @(negedge clk_i);
        end
        done_pulse(); #1;
        chk("t5_ready", st_req_ready_o, 1);
        chk("t5_req_idle", mem_req_o, 0);
        @(negedge clk_i); st_req_valid_i = 1'b0; #1;
        chk("t5_req",  mem_req_o, 1);
        chk("t5_addr", mem_addr_o, 32'h5000);
        wait_done(lat);
        chk("t5_lat", lat, 3);
        chk("t5_id",  done_insn_id_o, 4'd2);
        done_pulse();

        // T6: reset mid-ISSUE with 2 outstanding, stale acks afterwards
        @(negedge clk_i); ack_auto = 1'b0; desc(32'h6000, 16'd32, 4'd4);
        @(negedge clk_i); st_req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0; #1;
        chk("t6_rst_req",   mem_req_o, 0);
        chk("t6_rst_opgnt", store_op_gnt_o, 0);
        chk("t6_rst_be",    mem_be_o, 0);
        chk("t6_rst_ready", st_req_ready_o, 0);
        chk("t6_rst_done",  done_o, 0);
        @(negedge clk_i); rst_ni = 1'b1; ack_man = 1'b1;
        repeat (2) @(negedge clk_i);
        ack_man = 1'b0; ack_auto = 1'b1;
        desc(32'h7000, 16'd8, 4'd6); #1;
        chk("t6_ready", st_req_ready_o, 1);
        @(negedge clk_i); st_req_valid_i = 1'b0; #1;
        chk("t6_req",  mem_req_o, 1);
        chk("t6_addr", mem_addr_o, 32'h7000);
        wait_done(lat);
        chk("t6_lat", lat, 3);
        chk("t6_id",  done_insn_id_o, 4'd6);
        done_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
